// File: rtl/stats_merge_avlstrm_if.sv
// Stats beat layout and the Avalon-ST handshake bundle shared by
// the stats packers, the merger and the stats unpacker.
package stats_pkg;
   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] val;
   } stats_t;
endpackage

interface avl_stream_if #(
   parameter int W = $bits(stats_pkg::stats_t)
);
   logic         valid;
   logic         ready;
   logic         sop;
   logic         eop;
   logic [W-1:0] data;

   modport tx (output valid, sop, eop, data, input ready);
   modport rx (input valid, sop, eop, data, output ready);
endinterface

// File: rtl/stats_merge_avlstrm.sv
// Round-robin merge of NUM_IN single-beat stats streams, each behind
// a 2-entry FIFO, into one registered stream for the register file.
module stats_merge_avlstrm
   import stats_pkg::*;
#(
   parameter int NUM_IN = 2,
   parameter int DATA_W = $bits(stats_t)
) (
   input  logic        Clk,
   input  logic        Rst_n,
   avl_stream_if.rx    stats_in [NUM_IN],
   avl_stream_if.tx    stats_out,
   output logic [31:0] fwd_cnt
);
   localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   logic [DATA_W-1:0] in_data [NUM_IN];
   logic [DATA_W-1:0] q [NUM_IN][2];
   logic [1:0]        cnt [NUM_IN];
   logic [NUM_IN-1:0] in_valid;
   logic [NUM_IN-1:0] in_ready;
   logic [NUM_IN-1:0] push;
   logic [NUM_IN-1:0] pop;
   logic [NUM_IN-1:0] req;
   logic [IW-1:0]     last;
   logic [IW-1:0]     gnt_idx;
   logic [IW-1:0]     idx;
   logic              found;
   logic              grant;
   logic              load_ok;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;

   for (genvar g = 0; g < NUM_IN; g++) begin : g_in
      assign in_valid[g]       = stats_in[g].valid;
      assign in_data[g]        = stats_in[g].data;
      assign stats_in[g].ready = in_ready[g];
      assign in_ready[g]       = (cnt[g] != 2'd2);
      assign req[g]            = (cnt[g] != 2'd0);
      assign push[g]           = in_valid[g] && in_ready[g];
      assign pop[g]            = grant && (gnt_idx == IW'(g));
   end

   // Rotating search: first requester after the last winner.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      idx     = last;
      for (int k = 0; k < NUM_IN; k++) begin
         idx = (idx == IW'(NUM_IN - 1)) ? '0 : idx + IW'(1);
         if (!found && req[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign load_ok = !out_valid || stats_out.ready;
   assign grant   = load_ok && found;

   always_ff @(posedge Clk) begin
      for (int i = 0; i < NUM_IN; i++) begin
         if (!Rst_n)
            cnt[i] <= '0;
         else
            cnt[i] <= cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]};
      end
   end

   // Head is always q[i][0]; a pop shifts the tail (or the incoming beat) up.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < NUM_IN; i++) begin
         if (pop[i])
            q[i][0] <= (cnt[i] == 2'd2) ? q[i][1] : in_data[i];
         else if (push[i] && cnt[i] == 2'd0)
            q[i][0] <= in_data[i];
         if (push[i] && !pop[i] && cnt[i] == 2'd1)
            q[i][1] <= in_data[i];
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         last      <= IW'(NUM_IN - 1);
         fwd_cnt   <= '0;
      end else begin
         if (load_ok) begin
            out_valid <= found;
            if (found) begin
               out_data <= q[gnt_idx][0];
               last     <= gnt_idx;
            end
         end
         if (out_valid && stats_out.ready)
            fwd_cnt <= fwd_cnt + 32'd1;
      end
   end

   assign stats_out.valid = out_valid;
   assign stats_out.sop   = out_valid;
   assign stats_out.eop   = out_valid;
   assign stats_out.data  = out_data;
endmodule

// File: tb/tb_stats_merge_avlstrm.sv
// Scoreboard bench for stats_merge_avlstrm: source index is carried
// in addr[7:6] so each output beat is matched to its input's queue.
module tb_stats_merge_avlstrm;
   import stats_pkg::*;

   localparam int NI = 3;
   localparam int DW = $bits(stats_t);

   logic          Clk = 1'b0;
   logic          Rst_n = 1'b0;
   logic          in_v [NI];
   logic [DW-1:0] in_d [NI];
   logic          in_r [NI];
   logic          out_rdy;
   logic [31:0]   fwd_cnt;

   always #5 Clk = ~Clk;

   avl_stream_if #(.W(DW)) in_if [NI] ();
   avl_stream_if #(.W(DW)) out_if ();

   for (genvar g = 0; g < NI; g++) begin : g_drv
      assign in_if[g].valid = in_v[g];
      assign in_if[g].data  = in_d[g];
      assign in_if[g].sop   = 1'b1;
      assign in_if[g].eop   = 1'b1;
      assign in_r[g]        = in_if[g].ready;
   end
   assign out_if.ready = out_rdy;

   stats_merge_avlstrm #(.NUM_IN(NI), .DATA_W(DW)) dut (
      .Clk(Clk),
      .Rst_n(Rst_n),
      .stats_in(in_if),
      .stats_out(out_if),
      .fwd_cnt(fwd_cnt)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [DW-1:0] mk(int src, logic [5:0] a, logic [31:0] v);
      stats_t s;
      s.addr = {src[1:0], a};
      s.val  = v;
      return s;
   endfunction

   function automatic int src_of(logic [DW-1:0] d);
      stats_t s;
      s = d;
      return int'(s.addr[7:6]);
   endfunction

   // Scoreboard: accepted input beats queue per source; output pops.
   logic [DW-1:0] expq [NI][$];
   logic [31:0]   mcnt = '0;
   int            msrc;

   always @(negedge Clk) begin
      if (!Rst_n) begin
         for (int i = 0; i < NI; i++) expq[i].delete();
         mcnt = '0;
      end else begin
         chk("fwd_cnt", fwd_cnt, mcnt);
         for (int i = 0; i < NI; i++)
            if (in_v[i] && in_r[i]) expq[i].push_back(in_d[i]);
         if (out_if.valid && out_rdy) begin
            chk("sop_eop", {out_if.sop, out_if.eop}, 2'b11);
            msrc = src_of(out_if.data);
            if (msrc >= NI || expq[msrc].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %0h expected none", out_if.data);
            end else begin
               chk("beat_data", out_if.data, expq[msrc].pop_front());
            end
            mcnt = mcnt + 32'd1;
         end
      end
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic all_valid(logic v, int seq);
      for (int i = 0; i < NI; i++) begin
         in_v[i] = v;
         in_d[i] = mk(i, 6'(seq), $urandom);
      end
   endtask

   logic [DW-1:0] b0, b1, b2;
   int            n, guard;
   logic          acc;

   initial begin
      out_rdy = 1'b1;
      all_valid(1'b1, 0);
      // reset with valid inputs held
      repeat (3) cyc();
      @(negedge Clk);
      for (int i = 0; i < NI; i++) chk("rst_ready", in_r[i], 1'b1);
      chk("rst_valid", out_if.valid, 1'b0);
      chk("rst_sop", out_if.sop, 1'b0);
      chk("rst_fwd", fwd_cnt, 32'd0);
      cyc();
      Rst_n = 1'b1;
      all_valid(1'b0, 0);
      repeat (4) begin
         @(negedge Clk);
         chk("idle_valid", out_if.valid, 1'b0);
      end

      // single beat on input 1: visible two cycles later only
      cyc();
      b1 = mk(1, 6'd5, 32'h1234);
      in_v[1] = 1'b1;
      in_d[1] = b1;
      @(negedge Clk);
      chk("lat_t0", out_if.valid, 1'b0);
      cyc();
      in_v[1] = 1'b0;
      @(negedge Clk);
      chk("lat_t1", out_if.valid, 1'b0);
      @(negedge Clk);
      chk("lat_t2_valid", {out_if.valid, out_if.sop, out_if.eop}, 3'b111);
      chk("lat_t2_data", out_if.data, b1);
      @(negedge Clk);
      chk("lat_t3_valid", out_if.valid, 1'b0);
      chk("lat_fwd", fwd_cnt, 32'd1);

      // round-robin from reset: 0,1,2,0,1,2
      cyc();
      Rst_n = 1'b0;
      cyc();
      cyc();
      Rst_n = 1'b1;
      all_valid(1'b1, 0);
      cyc();
      all_valid(1'b1, 1);
      cyc();
      all_valid(1'b0, 0);
      for (int k = 0; k < 6; k++) begin
         @(negedge Clk);
         chk("rr_valid", out_if.valid, 1'b1);
         chk("rr_src", src_of(out_if.data), k % NI);
      end
      @(negedge Clk);
      chk("rr_end_valid", out_if.valid, 1'b0);
      chk("rr_fwd", fwd_cnt, 32'd6);

      // backpressure: output register stalled, then 3 beats on input 0
      cyc();
      out_rdy = 1'b0;
      in_v[1] = 1'b1;
      in_d[1] = mk(1, 6'd9, $urandom);
      cyc();
      in_v[1] = 1'b0;
      repeat (2) cyc();
      n = 0;
      in_v[0] = 1'b1;
      in_d[0] = mk(0, 6'(n), $urandom);
      repeat (8) begin
         @(negedge Clk);
         acc = in_r[0];
         cyc();
         if (acc) begin
            n++;
            in_d[0] = mk(0, 6'(n), $urandom);
         end
      end
      chk("bp_accepted", n, 2);
      chk("bp_ready", in_r[0], 1'b0);
      out_rdy = 1'b1;
      guard = 0;
      while (n < 3 && guard < 10) begin
         @(negedge Clk);
         acc = in_r[0];
         cyc();
         if (acc) n++;
         guard++;
      end
      in_v[0] = 1'b0;
      chk("bp_third_accepted", n, 3);
      repeat (6) cyc();

      // stall hold: input 2 beat sits in a stalled output register
      out_rdy = 1'b0;
      b2 = mk(2, 6'd1, $urandom);
      in_v[2] = 1'b1;
      in_d[2] = b2;
      cyc();
      in_v[2] = 1'b0;
      cyc();
      b0 = mk(0, 6'd2, $urandom);
      b1 = mk(1, 6'd3, $urandom);
      in_v[0] = 1'b1;
      in_d[0] = b0;
      in_v[1] = 1'b1;
      in_d[1] = b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         chk("stall_valid", out_if.valid, 1'b1);
         chk("stall_data", out_if.data, b2);
         cyc();
         in_v[0] = 1'b0;
         in_v[1] = 1'b0;
      end
      out_rdy = 1'b1;
      @(negedge Clk);
      chk("rel_first", out_if.data, b2);
      @(negedge Clk);
      chk("rel_next0", out_if.data, b0);
      @(negedge Clk);
      chk("rel_next1", out_if.data, b1);

      // counter wrap
      cyc();
      cyc();
      force dut.fwd_cnt = 32'hFFFF_FFFE;
      mcnt = 32'hFFFF_FFFE;
      #2;
      release dut.fwd_cnt;
      for (int k = 0; k < 3; k++) begin
         in_v[0] = 1'b1;
         in_d[0] = mk(0, 6'(k), $urandom);
         cyc();
      end
      in_v[0] = 1'b0;
      repeat (4) cyc();
      @(negedge Clk);
      chk("wrap_fwd", fwd_cnt, 32'd1);

      // reset with FIFOs and output register occupied
      cyc();
      out_rdy = 1'b0;
      all_valid(1'b1, 7);
      cyc();
      all_valid(1'b1, 8);
      cyc();
      all_valid(1'b0, 0);
      Rst_n = 1'b0;
      cyc();
      cyc();
      @(negedge Clk);
      for (int i = 0; i < NI; i++) chk("mid_rst_ready", in_r[i], 1'b1);
      chk("mid_rst_valid", out_if.valid, 1'b0);
      cyc();
      Rst_n = 1'b1;
      out_rdy = 1'b1;
      repeat (6) begin
         @(negedge Clk);
         chk("no_stale", out_if.valid, 1'b0);
      end

      // random traffic against the scoreboard
      for (int c = 0; c < 400; c++) begin
         cyc();
         for (int i = 0; i < NI; i++) begin
            in_v[i] = 1'($urandom_range(0, 1));
            in_d[i] = mk(i, 6'($urandom_range(0, 63)), $urandom);
         end
         out_rdy = ($urandom_range(0, 3) != 0);
      end
      cyc();
      all_valid(1'b0, 0);
      out_rdy = 1'b1;
      repeat (12) cyc();
      @(negedge Clk);
      for (int i = 0; i < NI; i++) chk("drained", expq[i].size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
